// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the AXI4-Lite register interface and the
// PWM register file.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   wr_state_t / rd_state_t : write and read channel FSM states
//   calc_depth()            : register count (one control word plus two
//                             words per PWM channel)
package pwm_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_EXEC,
        WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_EXEC,
        RD_RESP
    } rd_state_t;

    function automatic int calc_depth(input int num_channels);
        return 1 + 2 * num_channels;
    endfunction

endpackage

// File: rtl/axil_reg_if.sv
// axil_reg_if: AXI4-Lite slave that turns bus transactions into single-cycle
// register-file accesses. The write and read channels have independent FSMs,
// and each allows one outstanding transaction.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*    : AXI4-Lite write address, write data, write response
//   s_axil_ar*/r*       : AXI4-Lite read address, read data
//   write_en/addr/data  : one-cycle register write strobe and payload
//   read_en/addr        : one-cycle register read strobe and word index
//   read_data/valid     : combinational read result from the register file
module axil_reg_if
    import pwm_pkg::*;
#(
    parameter int REG_WIDTH      = 16,
    parameter int NUM_CHANNELS   = 4,
    parameter int AXI_ADDR_WIDTH = 8,
    localparam int DEPTH         = calc_depth(NUM_CHANNELS),
    localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [31:0]               s_axil_wdata,
    input  logic [3:0]                s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [31:0]               s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    output logic                      write_en,
    output logic [ADDR_WIDTH-1:0]     write_addr,
    output logic [31:0]               write_data,
    output logic                      read_en,
    output logic [ADDR_WIDTH-1:0]     read_addr,
    input  logic [31:0]               read_data,
    input  logic                      read_valid
);

    localparam logic [31:0] DEPTH_W = DEPTH;

    if (REG_WIDTH < 1 || REG_WIDTH > 32) begin : g_width_check
        $error("axil_reg_if: REG_WIDTH must be within 1..32");
    end

    // Dropping the byte-offset bits leaves the full word index. Any upper
    // address bit that is set makes that index >= DEPTH, so one compare
    // covers both out-of-range cases.
    function automatic logic addr_ok(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [31:0] idx;
        idx = 32'(a) >> 2;
        return idx < DEPTH_W;
    endfunction

    // ---------------- write channel ----------------
    wr_state_t             wr_state_reg, wr_state_next;
    logic                  aw_held_reg, aw_held_next;
    logic                  w_held_reg, w_held_next;
    logic [ADDR_WIDTH-1:0] aw_index_reg, aw_index_next;
    logic                  aw_ok_reg, aw_ok_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic                  wstrb_nz_reg, wstrb_nz_next;
    logic [1:0]            bresp_reg, bresp_next;

    always_comb begin
        wr_state_next  = wr_state_reg;
        aw_held_next   = aw_held_reg;
        w_held_next    = w_held_reg;
        aw_index_next  = aw_index_reg;
        aw_ok_next     = aw_ok_reg;
        wdata_next     = wdata_reg;
        wstrb_nz_next  = wstrb_nz_reg;
        bresp_next     = bresp_reg;
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        write_en       = 1'b0;
        case (wr_state_reg)
            WR_IDLE: begin
                s_axil_awready = !aw_held_reg;
                s_axil_wready  = !w_held_reg;
                if (s_axil_awvalid && !aw_held_reg) begin
                    aw_held_next  = 1'b1;
                    aw_index_next = s_axil_awaddr[ADDR_WIDTH+1:2];
                    aw_ok_next    = addr_ok(s_axil_awaddr);
                end
                if (s_axil_wvalid && !w_held_reg) begin
                    w_held_next   = 1'b1;
                    wdata_next    = s_axil_wdata;
                    wstrb_nz_next = |s_axil_wstrb;
                end
                // Leave as soon as both halves are in, including the cycle
                // in which the second (or both) handshakes happen.
                if (aw_held_next && w_held_next) begin
                    wr_state_next = WR_EXEC;
                end
            end
            WR_EXEC: begin
                // An all-zero strobe is accepted but writes nothing.
                write_en      = aw_ok_reg && wstrb_nz_reg;
                bresp_next    = aw_ok_reg ? RESP_OKAY : RESP_SLVERR;
                wr_state_next = WR_RESP;
            end
            WR_RESP: begin
                s_axil_bvalid = 1'b1;
                if (s_axil_bready) begin
                    aw_held_next  = 1'b0;
                    w_held_next   = 1'b0;
                    wr_state_next = WR_IDLE;
                end
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_reg <= WR_IDLE;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            aw_index_reg <= '0;
            aw_ok_reg    <= 1'b0;
            wdata_reg    <= '0;
            wstrb_nz_reg <= 1'b0;
            bresp_reg    <= RESP_OKAY;
        end else begin
            wr_state_reg <= wr_state_next;
            aw_held_reg  <= aw_held_next;
            w_held_reg   <= w_held_next;
            aw_index_reg <= aw_index_next;
            aw_ok_reg    <= aw_ok_next;
            wdata_reg    <= wdata_next;
            wstrb_nz_reg <= wstrb_nz_next;
            bresp_reg    <= bresp_next;
        end
    end

    assign write_addr   = aw_index_reg;
    assign write_data   = wdata_reg;
    assign s_axil_bresp = bresp_reg;

    // ---------------- read channel ----------------
    rd_state_t             rd_state_reg, rd_state_next;
    logic [ADDR_WIDTH-1:0] ar_index_reg, ar_index_next;
    logic                  ar_ok_reg, ar_ok_next;
    logic [31:0]           rdata_reg, rdata_next;
    logic [1:0]            rresp_reg, rresp_next;

    always_comb begin
        rd_state_next  = rd_state_reg;
        ar_index_next  = ar_index_reg;
        ar_ok_next     = ar_ok_reg;
        rdata_next     = rdata_reg;
        rresp_next     = rresp_reg;
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        read_en        = 1'b0;
        case (rd_state_reg)
            RD_IDLE: begin
                s_axil_arready = 1'b1;
                if (s_axil_arvalid) begin
                    ar_index_next = s_axil_araddr[ADDR_WIDTH+1:2];
                    ar_ok_next    = addr_ok(s_axil_araddr);
                    rd_state_next = RD_EXEC;
                end
            end
            RD_EXEC: begin
                read_en = ar_ok_reg;
                // Captured before any write in this same cycle lands, so a
                // colliding read returns the old contents.
                if (ar_ok_reg && read_valid) begin
                    rdata_next = read_data;
                    rresp_next = RESP_OKAY;
                end else begin
                    rdata_next = '0;
                    rresp_next = RESP_SLVERR;
                end
                rd_state_next = RD_RESP;
            end
            RD_RESP: begin
                s_axil_rvalid = 1'b1;
                if (s_axil_rready) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_reg <= RD_IDLE;
            ar_index_reg <= '0;
            ar_ok_reg    <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
        end else begin
            rd_state_reg <= rd_state_next;
            ar_index_reg <= ar_index_next;
            ar_ok_reg    <= ar_ok_next;
            rdata_reg    <= rdata_next;
            rresp_reg    <= rresp_next;
        end
    end

    assign read_addr    = ar_index_reg;
    assign s_axil_rdata = rdata_reg;
    assign s_axil_rresp = rresp_reg;

endmodule

// File: tb/tb_axil_reg_if.sv
// tb_axil_reg_if: directed-vector bench for axil_reg_if with a small register
// file model. Expected register writes, B responses and R responses are queued
// when stimulus is issued; a negedge monitor pops and compares them whenever
// the DUT presents write_en, a B handshake or an R handshake.
module tb_axil_reg_if;

    localparam int AW    = 8;
    localparam int AWID  = 4;
    localparam int DEPTH = 9;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic            write_en;
    logic [AWID-1:0] write_addr;
    logic [31:0]     write_data;
    logic            read_en;
    logic [AWID-1:0] read_addr;
    logic [31:0]     read_data;
    logic            read_valid;

    axil_reg_if dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_awaddr  (awaddr),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .write_en       (write_en),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .read_en        (read_en),
        .read_addr      (read_addr),
        .read_data      (read_data),
        .read_valid     (read_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: synchronous write, combinational read.
    logic [31:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    always @(posedge clk) if (write_en) mem[write_addr] <= write_data;
    assign read_valid = (read_addr < AWID'(DEPTH));
    assign read_data  = read_valid ? mem[read_addr] : 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [35:0] wq[$];   // {index, data}
    logic [1:0]  bq[$];
    logic [33:0] rq[$];   // {data, resp}

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_en) begin
                if (wq.size() == 0) chk("sb_unexpected_write_en", 1, 0);
                else chk("sb_write", {write_addr, write_data}, wq.pop_front());
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) chk("sb_unexpected_b", 1, 0);
                else chk("sb_bresp", bresp, bq.pop_front());
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) chk("sb_unexpected_r", 1, 0);
                else chk("sb_rdata_rresp", {rdata, rresp}, rq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b();
        int n = 0;
        while (!(bvalid && bready) && n < 20) begin step(); n++; end
        if (n == 20) chk("b_timeout", 1, 0);
        else step();
    endtask

    task automatic wait_r();
        int n = 0;
        while (!(rvalid && rready) && n < 20) begin step(); n++; end
        if (n == 20) chk("r_timeout", 1, 0);
        else step();
    endtask

    // AW and W presented in the same cycle, bready held high.
    task automatic wr_same(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic exp_wen, input logic [AWID-1:0] idx, input logic [1:0] resp);
        if (exp_wen) wq.push_back({idx, d});
        bq.push_back(resp);
        awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_write_en_n+1", write_en, exp_wen);
        step();
        chk("wr_bvalid_n+2", bvalid, 1'b1);
        wait_b();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] resp,
                      input logic exp_ren);
        rq.push_back({d, resp});
        araddr = a; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("rd_read_en_n+1", read_en, exp_ren);
        step();
        chk("rd_rvalid_n+2", rvalid, 1'b1);
        wait_r();
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
        step(); step();

        // Reset state
        chk("rst_ready", {awready, wready, arready}, 3'b111);
        chk("rst_valids", {bvalid, rvalid, write_en, read_en}, 4'b0000);
        chk("rst_resp_rdata", {bresp, rresp, rdata}, 36'h0);
        chk("rst_ports", {write_addr, write_data, read_addr}, 40'h0);
        rst_n = 1'b1;
        step();

        // AW 0x04 and W 0x1234 together
        wr_same(8'h04, 32'h0000_1234, 4'hF, 1'b1, 4'd1, OKAY);

        // W 0xBEEF three cycles ahead of AW 0x08
        wq.push_back({4'd2, 32'h0000_BEEF});
        bq.push_back(OKAY);
        wdata = 32'h0000_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("wfirst_wready_low", wready, 1'b0);
            chk("wfirst_no_write_en", write_en, 1'b0);
            step();
        end
        awaddr = 8'h08; awvalid = 1'b1;
        chk("wfirst_awready", awready, 1'b1);
        step();
        awvalid = 1'b0;
        chk("wfirst_write_en", write_en, 1'b1);
        chk("wfirst_wready_exec", wready, 1'b0);
        step();
        chk("wfirst_bvalid", bvalid, 1'b1);
        chk("wfirst_wready_resp", wready, 1'b0);
        wait_b();
        chk("wfirst_wready_back", wready, 1'b1);

        // Read 0x04 with rready low for 5 cycles
        rready = 1'b0;
        rq.push_back({32'h0000_1234, OKAY});
        araddr = 8'h04; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        chk("stall_read_en", {read_en, read_addr}, {1'b1, 4'd1});
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid_rdata", {rvalid, rdata, rresp}, {1'b1, 32'h0000_1234, OKAY});
            chk("stall_arready_low", arready, 1'b0);
            step();
        end
        rready = 1'b1;
        wait_r();

        // Out-of-range: index 9 and a set upper address bit
        wr_same(8'h24, 32'h0000_5555, 4'hF, 1'b0, 4'd0, SLVERR);
        wr_same(8'h44, 32'h0000_6666, 4'hF, 1'b0, 4'd0, SLVERR);
        rd(8'h24, 32'h0, SLVERR, 1'b0);
        rd(8'h44, 32'h0, SLVERR, 1'b0);

        // AW one cycle before W, last valid index; low address bits ignored on read
        wq.push_back({4'd8, 32'hA5A5_A5A5});
        bq.push_back(OKAY);
        awaddr = 8'h20; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        chk("awfirst_awready_low", awready, 1'b0);
        wdata = 32'hA5A5_A5A5; wstrb = 4'h1; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        chk("awfirst_write_en", write_en, 1'b1);
        wait_b();
        rd(8'h23, 32'hA5A5_A5A5, OKAY, 1'b1);

        // wstrb = 0 writes nothing but returns OKAY
        wr_same(8'h00, 32'h1111_1111, 4'h2, 1'b1, 4'd0, OKAY);
        wr_same(8'h00, 32'h0000_DEAD, 4'h0, 1'b0, 4'd0, OKAY);
        rd(8'h00, 32'h1111_1111, OKAY, 1'b1);

        // Read and write of index 2 in the same cycle: read sees old value
        wq.push_back({4'd2, 32'h0000_CAFE});
        bq.push_back(OKAY);
        rq.push_back({32'h0000_BEEF, OKAY});
        awaddr = 8'h08; awvalid = 1'b1; wdata = 32'h0000_CAFE; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 8'h08; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("collide_en", {write_en, read_en}, 2'b11);
        step();
        chk("collide_valids", {bvalid, rvalid}, 2'b11);
        step();
        rd(8'h08, 32'h0000_CAFE, OKAY, 1'b1);

        // Reset while holding a B response
        bready = 1'b0;
        wq.push_back({4'd3, 32'h0000_3333});
        awaddr = 8'h0C; awvalid = 1'b1; wdata = 32'h0000_3333; wstrb = 4'hF; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        step();
        step();
        chk("rstmid_bvalid_held", bvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_bvalid_drop", bvalid, 1'b0);
        chk("rstmid_ready", {awready, wready, arready}, 3'b111);
        step(); step();
        rst_n = 1'b1;
        bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_no_b", {bvalid, write_en}, 2'b00);
            step();
        end
        wr_same(8'h0C, 32'h0000_4444, 4'hF, 1'b1, 4'd3, OKAY);
        rd(8'h0C, 32'h0000_4444, OKAY, 1'b1);

        step(); step();
        chk("sb_wq_empty", wq.size(), 0);
        chk("sb_bq_empty", bq.size(), 0);
        chk("sb_rq_empty", rq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
